// File: rtl/regfile_wb.sv
// Write-back register file: 31 general registers plus a hard-wired zero (XZR),
// combinational reads with same-cycle write bypass, and a saturating commit counter.
module regfile_wb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [15:0]       WriteCount
);

  localparam int unsigned NDEC  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [4:0]  XZR   = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [NDEC-1:0]   we_vec;
  logic [3:0]        grp_en;
  logic [3:0]        sub_en;
  logic              commit;

  function automatic logic [3:0] dec24(input logic en, input logic [1:0] sel);
    logic [3:0] y;
    y      = 4'b0000;
    y[sel] = en;
    return y;
  endfunction

  // Two levels of 2-to-4 decoders select a register pair; bit 0 picks within the pair.
  always_comb begin
    we_vec = '0;
    sub_en = 4'b0000;
    grp_en = dec24(RegWrite, WriteRegister[4:3]);
    for (int g = 0; g < 4; g++) begin
      sub_en = dec24(grp_en[g], WriteRegister[2:1]);
      for (int p = 0; p < 4; p++) begin
        we_vec[g*8 + p*2]     = sub_en[p] & ~WriteRegister[0];
        we_vec[g*8 + p*2 + 1] = sub_en[p] &  WriteRegister[0];
      end
    end
  end

  // XZR's enable is decoded but never allowed to commit.
  assign commit = |we_vec[NDEC-2:0];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG - 1; i++) begin
      if (we_vec[i]) regs_d[i] = WriteData;
    end
    cnt_d = cnt_q;
    if (commit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypass is suppressed during reset so reads show stored contents.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (reset_n && RegWrite && (WriteRegister != XZR) && (WriteRegister == ReadRegister1))
      ReadData1 = WriteData;
    else if (ReadRegister1 != XZR)
      ReadData1 = regs_q[ReadRegister1];
    if (reset_n && RegWrite && (WriteRegister != XZR) && (WriteRegister == ReadRegister2))
      ReadData2 = WriteData;
    else if (ReadRegister2 != XZR)
      ReadData2 = regs_q[ReadRegister2];
  end

  assign WriteCount = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized and directed bench for regfile_wb: the driver queues expected read
// and count values from an array model; a negedge monitor pops and compares.
module tb_regfile_wb;

  logic        clk;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [15:0] WriteCount;

  regfile_wb #(.DATA_W(64), .NREG(32)) dut (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [15:0] ec;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mdl [32];
  int          mdl_cnt;
  int          checks = 0;
  int          errors = 0;

  // Architectural view of a read port given the inputs applied this cycle.
  function automatic logic [63:0] model_read(input logic [4:0] ra);
    if (reset_n && RegWrite && WriteRegister == ra && ra != 5'd31) return WriteData;
    if (ra == 5'd31) return 64'd0;
    return mdl[ra];
  endfunction

  // One clock cycle: apply inputs, optionally queue a check, then retire the edge in the model.
  task automatic cycle(input logic rst_n, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] ra1,
                       input logic [4:0] ra2, input bit chk, input string name);
    exp_t e;
    reset_n = rst_n; RegWrite = we; WriteRegister = wr; WriteData = wd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    if (chk) begin
      e.name = name;
      e.e1 = model_read(ra1);
      e.e2 = model_read(ra2);
      e.ec = 16'(mdl_cnt);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
      mdl_cnt = 0;
    end else if (we && wr != 5'd31) begin
      mdl[wr] = wd;
      if (mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks = checks + 1;
      if (ReadData1 !== e.e1) begin
        errors = errors + 1;
        $display("FAIL %s rd1: got %h expected %h", e.name, ReadData1, e.e1);
      end
      checks = checks + 1;
      if (ReadData2 !== e.e2) begin
        errors = errors + 1;
        $display("FAIL %s rd2: got %h expected %h", e.name, ReadData2, e.e2);
      end
      checks = checks + 1;
      if (WriteCount !== e.ec) begin
        errors = errors + 1;
        $display("FAIL %s count: got %0d expected %0d", e.name, WriteCount, e.ec);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    mdl_cnt = 0;
    reset_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    @(posedge clk); #1;

    // Reset, then every address reads zero.
    cycle(1'b0, 1'b1, 5'd4, 64'h55, 5'd0, 5'd0, 1'b0, "reset");
    for (int i = 0; i < 32; i++)
      cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 1'b1, "reset_read");

    // Write Xi = i*0x0101, then read everything back.
    for (int i = 0; i < 31; i++)
      cycle(1'b1, 1'b1, 5'(i), 64'(i) * 64'h0101, 5'(i), 5'((i + 1) % 32), 1'b1, "write");
    for (int i = 0; i < 32; i++)
      cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 1'b1, "readback");

    // XZR write is ignored and not counted.
    cycle(1'b1, 1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd31, 1'b1, "xzr_during");
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31, 1'b1, "xzr_after");

    // Bypass on both ports.
    cycle(1'b1, 1'b1, 5'd5, 64'd7, 5'd0, 5'd1, 1'b0, "x5_store");
    cycle(1'b1, 1'b0, 5'd5, 64'd9, 5'd5, 5'd5, 1'b1, "nobypass");
    cycle(1'b1, 1'b1, 5'd5, 64'd9, 5'd5, 5'd5, 1'b1, "bypass");
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 1'b1, "bypass_after");

    // Reset colliding with a write.
    cycle(1'b1, 1'b1, 5'd3, 64'd1, 5'd0, 5'd0, 1'b0, "x3_store");
    cycle(1'b0, 1'b1, 5'd3, 64'd5, 5'd3, 5'd3, 1'b1, "rst_collide");
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3, 1'b1, "rst_after");

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom),
            {$urandom, $urandom}, 5'($urandom), 5'($urandom), 1'b1, "random");

    // Saturation: 65540 commits from a fresh reset.
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, "sat_reset");
    for (int n = 0; n < 65540; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 30));
      cycle(1'b1, 1'b1, wr, {$urandom, $urandom}, wr, 5'($urandom),
            (n >= 65530 || n % 4096 == 0), "saturate");
    end
    for (int n = 0; n < 3; n++)
      cycle(1'b1, 1'b1, 5'd7, 64'd1, 5'd7, 5'd31, 1'b1, "sat_hold");

    RegWrite = 1'b0;
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
